parser_arbiter: RTL and testbench

Round-robin arbiter that shares one trade-packet parser between NUM_SRC upstream feed sources. It accepts 128-bit packets over a per-source valid/ready handshake and issues them to the parser as one-cycle packetInValid pulses. Issues are spaced at least two cycles apart, because the parser needs its PARSE recovery cycle. It tags each issue with the source ID, checks the parser's same-cycle parsedValid response, and keeps per-source grant statistics.

---
 rtl/parser_pkg.sv | 24 ++
 rtl/rr_picker.sv | 30 +++
 rtl/parser_arbiter.sv | 116 +++++++++++
 tb/tb_parser_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared types and trade-field layout for the parser front end.
// The parser and the parser_arbiter both import this package.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int PKT_W = 128;

  localparam int TRADE_ID_MSB = 127;
  localparam int TRADE_ID_LSB = 112;
  localparam int PRICE_MSB    = 111;
  localparam int PRICE_LSB    = 80;
  localparam int QTY_MSB      = 79;
  localparam int QTY_LSB      = 64;

  function automatic logic [15:0] trade_id(input logic [PKT_W-1:0] pkt);
    return pkt[TRADE_ID_MSB:TRADE_ID_LSB];
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping modulo NUM_SRC, wins.
module rr_picker #(
  parameter int  NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic               gnt_valid_o,
  output logic [SRC_W-1:0]   gnt_idx_o
);

  int idx;

  // Walk the search order backwards so the lowest offset from ptr_i wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req_i[SRC_W'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/parser_arbiter.sv
// Round-robin arbiter sharing one trade-packet parser between NUM_SRC feeds,
// with issue spacing, handshake error detection and per-source grant counters.
//
// state | meaning
// IDLE  | nothing in flight; may accept a packet
// ISSUE | packetInValid high for the packet accepted last cycle
// GAP   | parser recovery cycle; may accept the next packet
module parser_arbiter #(
  parameter int  NUM_SRC = 4,
  parameter int  PKT_W   = parser_pkg::PKT_W,
  parameter int  CNT_W   = 16,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_SRC-1:0]       srcValid,
  input  logic [NUM_SRC*PKT_W-1:0] srcPacket,
  input  logic [NUM_SRC-1:0]       srcEnable,
  output logic [NUM_SRC-1:0]       srcReady,
  output logic [PKT_W-1:0]         packetIn,
  output logic                     packetInValid,
  output logic [SRC_W-1:0]         issueSrc,
  input  logic                     parsedValid,
  input  logic [SRC_W-1:0]         statSel,
  input  logic                     statClr,
  output logic [CNT_W-1:0]         statCnt,
  output logic                     errSticky
);

  import parser_pkg::*;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PKT_W-1:0]   pkt_q;
  logic [SRC_W-1:0]   src_q;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic               err_q;

  logic [NUM_SRC-1:0] eligible;
  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;
  logic               accept;

  assign eligible = srcValid & srcEnable;

  rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // rstn gates the accept so srcReady stays low for the whole reset window.
  assign accept = rstn && gnt_valid && (state_q != ISSUE);

  always_comb begin
    srcReady = '0;
    if (accept) srcReady[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = GAP;
      GAP:     state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      pkt_q    <= '0;
      src_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        pkt_q <= srcPacket[int'(gnt_idx)*PKT_W +: PKT_W];
        src_q <= gnt_idx;
      end
      if ((packetInValid && !parsedValid) || (parsedValid && !packetInValid)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Clear has priority over a coinciding grant; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (statClr) begin
          cnt_q[i] <= '0;
        end else if (accept && (gnt_idx == SRC_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign packetInValid = (state_q == ISSUE);
  assign packetIn      = pkt_q;
  assign issueSrc      = src_q;
  assign errSticky     = err_q;
  assign statCnt       = (int'(statSel) < NUM_SRC) ? cnt_q[statSel] : '0;

endmodule

// File: tb/tb_parser_arbiter.sv
// Directed self-checking bench for parser_arbiter; counters are built 4 bits
// wide here so saturation is reachable in a short run.
module tb_parser_arbiter;
  import parser_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int PW      = 128;
  localparam int CW      = 4;
  localparam int SW      = 2;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NUM_SRC-1:0]    srcValid = '0;
  logic [NUM_SRC*PW-1:0] srcPacket = '0;
  logic [NUM_SRC-1:0]    srcEnable = '1;
  logic [NUM_SRC-1:0]    srcReady;
  logic [PW-1:0]         packetIn;
  logic                  packetInValid;
  logic [SW-1:0]         issueSrc;
  logic                  parsedValid;
  logic [SW-1:0]         statSel = '0;
  logic                  statClr = 1'b0;
  logic [CW-1:0]         statCnt;
  logic                  errSticky;
  logic                  pv_kill = 1'b0;

  int checks = 0;
  int errors = 0;

  // Well-behaved parser: answers in the same cycle unless told to drop it.
  assign parsedValid = packetInValid & ~pv_kill;

  always #5 clk = ~clk;

  parser_arbiter #(.NUM_SRC(NUM_SRC), .PKT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .srcValid(srcValid), .srcPacket(srcPacket),
    .srcEnable(srcEnable), .srcReady(srcReady), .packetIn(packetIn),
    .packetInValid(packetInValid), .issueSrc(issueSrc), .parsedValid(parsedValid),
    .statSel(statSel), .statClr(statClr), .statCnt(statCnt), .errSticky(errSticky)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    srcValid = '0;
    statClr  = 1'b0;
    pv_kill  = 1'b0;
    step();
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int src, input int exp);
    statSel = SW'(src);
    #1;
    chk(tag, 128'(statCnt), 128'(exp));
  endtask

  initial begin
    int n_issue;
    logic prev_pv;
    logic [SW-1:0] exp_order [8];

    for (int i = 0; i < NUM_SRC; i++)
      srcPacket[i*PW +: PW] = {16'(i + 1), 32'h0000_0064, 16'h000A, 64'hA5A5_0000_0000_0000 + 64'(i)};

    // Reset values
    do_reset();
    chk("rst_pv", 128'(packetInValid), 128'd0);
    chk("rst_issueSrc", 128'(issueSrc), 128'd0);
    chk("rst_packetIn", 128'(packetIn), 128'd0);
    chk("rst_err", 128'(errSticky), 128'd0);

    // 1: single packet from source 0
    srcValid = 4'b0001;
    #1;
    chk("t1_ready", 128'(srcReady), 128'b0001);
    chk("t1_pv_n", 128'(packetInValid), 128'd0);
    step();
    srcValid = 4'b0000;
    #1;
    chk("t1_pv", 128'(packetInValid), 128'd1);
    chk("t1_src", 128'(issueSrc), 128'd0);
    chk("t1_tradeid", 128'(trade_id(packetIn)), 128'h0001);
    chk("t1_pkt", 128'(packetIn), {16'h0001, 32'h0000_0064, 16'h000A, 64'hA5A5_0000_0000_0000});
    chk_cnt("t1_cnt0", 0, 1);
    step();
    chk("t1_pv_gap", 128'(packetInValid), 128'd0);
    chk("t1_hold", 128'(trade_id(packetIn)), 128'h0001);
    chk("t1_err", 128'(errSticky), 128'd0);

    // 2: all four sources valid for 16 cycles
    do_reset();
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    srcValid = 4'b1111;
    n_issue = 0;
    prev_pv = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (packetInValid) begin
        chk("t2_backtoback", 128'(prev_pv), 128'd0);
        if (n_issue < 8) chk("t2_order", 128'(issueSrc), 128'(exp_order[n_issue]));
        n_issue++;
      end
      chk("t2_pv_phase", 128'(packetInValid), 128'(c % 2));
      prev_pv = packetInValid;
      step();
    end
    srcValid = '0;
    chk("t2_nissue", 128'(n_issue), 128'd8);
    for (int i = 0; i < NUM_SRC; i++) chk_cnt("t2_cnt", i, 2);
    chk("t2_err", 128'(errSticky), 128'd0);

    // 3: enable mask 1010
    do_reset();
    srcEnable = 4'b1010;
    srcValid  = 4'b1111;
    exp_order = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    n_issue = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (packetInValid) begin
        if (n_issue < 4) chk("t3_order", 128'(issueSrc), 128'(exp_order[n_issue]));
        n_issue++;
      end
      step();
    end
    srcValid  = '0;
    srcEnable = 4'b1111;
    chk("t3_nissue", 128'(n_issue), 128'd4);
    chk_cnt("t3_cnt0", 0, 0);
    chk_cnt("t3_cnt1", 1, 2);
    chk_cnt("t3_cnt2", 2, 0);
    chk_cnt("t3_cnt3", 3, 2);

    // 4: parser drops its response during ISSUE
    do_reset();
    srcValid = 4'b0100;
    step();
    srcValid = '0;
    pv_kill  = 1'b1;
    #1;
    chk("t4_pv", 128'(packetInValid), 128'd1);
    chk("t4_err_before", 128'(errSticky), 128'd0);
    step();
    pv_kill = 1'b0;
    chk("t4_err_set", 128'(errSticky), 128'd1);
    step();
    step();
    chk("t4_err_held", 128'(errSticky), 128'd1);
    do_reset();
    chk("t4_err_clr", 128'(errSticky), 128'd0);

    // 5: saturation (all-ones = 15 here) and clear-vs-grant priority
    do_reset();
    srcValid = 4'b0100;
    repeat (28) step();
    srcValid = '0;
    step();
    chk_cnt("t5_cnt_e", 2, 14);
    srcValid = 4'b0100;
    repeat (6) step();
    srcValid = '0;
    step();
    chk_cnt("t5_sat", 2, 15);
    chk("t5_err", 128'(errSticky), 128'd0);
    srcValid = 4'b0100;
    statClr  = 1'b1;
    #1;
    chk("t5_clr_accept", 128'(srcReady), 128'b0100);
    step();
    srcValid = '0;
    statClr  = 1'b0;
    chk_cnt("t5_clr_wins", 2, 0);

    // 6: reset during the ISSUE cycle
    do_reset();
    srcValid = 4'b0100;
    step();
    srcValid = 4'b0010;
    rstn = 1'b0;
    #1;
    chk("t6_pv_rst", 128'(packetInValid), 128'd0);
    chk("t6_ready_rst", 128'(srcReady), 128'd0);
    chk("t6_src_rst", 128'(issueSrc), 128'd0);
    step();
    chk("t6_ready_rst2", 128'(srcReady), 128'd0);
    srcValid = '0;
    rstn = 1'b1;
    prev_pv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      prev_pv = prev_pv | packetInValid;
    end
    chk("t6_no_pulse", 128'(prev_pv), 128'd0);
    srcValid = 4'b1111;
    #1;
    chk("t6_ptr0", 128'(srcReady), 128'b0001);
    srcValid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
